umul_seq_ctrl: RTL

- Sequencer for one unary-rate inner multiplier (rate-coded input bit × Sobol-compared weight).
- Accepts an operand pair over a valid/ready handshake and latches it.
- Clears the multiplier's Sobol generator, then rate-codes the input operand into a bitstream over a fixed window of 2^CYC_W cycles.
- Counts the multiplier's output ones and returns the count over a valid/ready handshake. Sits between the PE operand feed and the multiplier.

---
 rtl/umul_seq_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/umul_seq_ctrl.sv
// umul_seq_ctrl: sequencer for one unary-rate inner multiplier.
//
// Accepts an operand pair, clears the multiplier's Sobol generator for one cycle, then
// rate-codes the input magnitude into a bitstream over a window of 2^CYC_W cycles while
// counting the ones the multiplier returns. The count is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        operand handshake; in_data_i is rate-coded, in_data_w forwarded
//   abort                    cancel the current operation, no result produced
//   mul_rst_n                registered active-low clear for the multiplier's Sobol generator
//   mul_bit_i, mul_data_w    input bitstream and latched weight to the multiplier
//   mul_bit                  multiplier output bit (combinational in the multiplier)
//   out_valid/out_ready      result handshake; out_count = ones of mul_bit over the window
//   busy                     block is not idle
module umul_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] in_data_i,
    input  logic [WIDTH-2:0] in_data_w,
    input  logic             abort,
    output logic             mul_rst_n,
    output logic             mul_bit_i,
    output logic [WIDTH-2:0] mul_data_w,
    input  logic             mul_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CYC_W:0]   out_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    localparam logic [CYC_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] ri_q, ri_d;       // only the top CYC_W magnitude bits are rate-coded
    logic [WIDTH-2:0] rw_q, rw_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [CYC_W:0]   acc_q, acc_d;
    logic [CYC_W:0]   out_count_q, out_count_d;
    logic             mul_rst_n_q, mul_rst_n_d;
    logic [CYC_W:0]   acc_inc;

    // Low magnitude bits below the rate-coded slice are intentionally dropped.
    logic unused_in_data_i;
    assign unused_in_data_i = ^in_data_i;

    function automatic logic [CYC_W-1:0] bitrev(input logic [CYC_W-1:0] v);
        logic [CYC_W-1:0] r;
        for (int i = 0; i < int'(CYC_W); i++) begin
            r[i] = v[int'(CYC_W) - 1 - i];
        end
        return r;
    endfunction

    assign acc_inc = acc_q + {{CYC_W{1'b0}}, mul_bit};

    always_comb begin
        state_d     = state_q;
        ri_d        = ri_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_count_d = out_count_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ri_d    = in_data_i[WIDTH-2 -: CYC_W];
                    rw_d    = in_data_w;
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                acc_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_inc;
                if (cnt_q == CntMax) begin
                    // Include the final cycle's bit, which acc_q has not seen yet.
                    out_count_d = acc_inc;
                    acc_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // abort outranks window completion and out_ready.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            acc_d   = '0;
        end

        // Registered so the Sobol clear is glitch-free and lines up with the CLEAR cycle.
        mul_rst_n_d = (state_d != StClear);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ri_q        <= '0;
            rw_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_count_q <= '0;
            mul_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ri_q        <= ri_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_count_q <= out_count_d;
            mul_rst_n_q <= mul_rst_n_d;
        end
    end

    // Bit-reversed counter acts as a low-discrepancy threshold, so the stream for value v
    // carries exactly v ones over the full window.
    assign mul_bit_i  = (state_q == StRun) && (ri_q > bitrev(cnt_q));
    assign mul_data_w = rw_q;
    assign mul_rst_n  = mul_rst_n_q;
    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_count  = out_count_q;
    assign busy       = (state_q != StIdle);

endmodule
